// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, instruction fields, fetch states.
package pacote_cpu;

    localparam int LARG_OPCODE   = 4;
    localparam int LARG_OPERANDO = 4;
    localparam int LARG_INSTR    = LARG_OPCODE + LARG_OPERANDO;

    localparam logic [LARG_OPCODE-1:0] OP_ADD = 4'b0000;
    localparam logic [LARG_OPCODE-1:0] OP_SUB = 4'b0001;
    localparam logic [LARG_OPCODE-1:0] OP_LDA = 4'b0010;
    localparam logic [LARG_OPCODE-1:0] OP_STA = 4'b0011;
    localparam logic [LARG_OPCODE-1:0] OP_LDB = 4'b0100;
    localparam logic [LARG_OPCODE-1:0] OP_STB = 4'b0101;
    localparam logic [LARG_OPCODE-1:0] OP_LDC = 4'b0110;
    localparam logic [LARG_OPCODE-1:0] OP_JMP = 4'b0111;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        BUSCA  = 2'd1,
        EMITE  = 2'd2,
        ERRO   = 2'd3
    } estado_t;

    // Any word with the top opcode bit set is outside the instruction set.
    function automatic logic eh_ilegal(input logic [LARG_INSTR-1:0] instr);
        return instr[LARG_INSTR-1];
    endfunction

endpackage

// File: rtl/contador_programa.sv
// Program counter: load has priority over increment, wraps modulo 256.
module contador_programa #(
    parameter logic [7:0] PC_INICIAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       carregar,
    input  logic [7:0] valor,
    input  logic       incrementar,
    output logic [7:0] pc
);

    logic [7:0] r_pc;

    // PC register update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_INICIAL;
        end else if (carregar) begin
            r_pc <= valor;
        end else if (incrementar) begin
            r_pc <= r_pc + 8'd1;
        end else begin
            r_pc <= r_pc;
        end
    end

    assign pc = r_pc;

endmodule

// File: rtl/busca_instrucao.sv
// Fetch/decode unit: reads the program ROM, holds the IR and hands instructions to execute over valid/ready.
module busca_instrucao
    import pacote_cpu::*;
#(
    parameter logic [7:0] PC_INICIAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    output logic [7:0] ler_endereco,
    input  logic [7:0] instrucao_in,
    input  logic       a_zero,
    output logic       instr_valida,
    input  logic       instr_pronta,
    output logic [3:0] opcode,
    output logic [3:0] operando,
    output logic [7:0] pc,
    output logic       ocupado,
    output logic       erro
);

    estado_t    r_estado;
    logic [7:0] r_ir;
    logic       r_valida;
    logic       r_ocupado;
    logic       r_erro;

    logic       w_transfere;
    logic       w_carregar;
    logic       w_incrementar;
    logic [7:0] w_pc;

    assign w_transfere   = r_valida && instr_pronta;
    assign w_carregar    = w_transfere && (r_ir[7:4] == OP_JMP) && a_zero;
    assign w_incrementar = w_transfere && !w_carregar;

    contador_programa #(
        .PC_INICIAL (PC_INICIAL)
    ) u_contador_programa (
        .clk         (clk),
        .reset       (reset),
        .carregar    (w_carregar),
        .valor       ({4'h0, r_ir[3:0]}),
        .incrementar (w_incrementar),
        .pc          (w_pc)
    );

    // Fetch FSM with IR capture and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado  <= OCIOSO;
            r_ir      <= 8'h00;
            r_valida  <= 1'b0;
            r_ocupado <= 1'b0;
            r_erro    <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (iniciar) begin
                        r_estado  <= BUSCA;
                        r_ocupado <= 1'b1;
                    end else begin
                        r_estado  <= OCIOSO;
                    end
                end
                BUSCA: begin
                    r_ir <= instrucao_in;
                    if (eh_ilegal(instrucao_in)) begin
                        r_estado  <= ERRO;
                        r_valida  <= 1'b0;
                        r_ocupado <= 1'b0;
                        r_erro    <= 1'b1;
                    end else begin
                        r_estado  <= EMITE;
                        r_valida  <= 1'b1;
                        r_ocupado <= 1'b1;
                    end
                end
                EMITE: begin
                    if (instr_pronta) begin
                        r_estado <= BUSCA;
                        r_valida <= 1'b0;
                    end else begin
                        r_estado <= EMITE;
                    end
                end
                ERRO: begin
                    r_estado  <= ERRO;
                    r_valida  <= 1'b0;
                    r_ocupado <= 1'b0;
                    r_erro    <= 1'b1;
                end
                default: begin
                    r_estado  <= OCIOSO;
                    r_valida  <= 1'b0;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign ler_endereco = w_pc;
    assign pc           = w_pc;
    assign opcode       = r_ir[7:4];
    assign operando     = r_ir[3:0];
    assign instr_valida = r_valida;
    assign ocupado      = r_ocupado;
    assign erro         = r_erro;

endmodule

// File: tb/tb_busca_instrucao.sv
// Scoreboard bench for busca_instrucao: directed program with jump, backpressure, trap and wrap cases.
module tb_busca_instrucao;

    typedef struct {
        logic [3:0] op;
        logic [3:0] opnd;
        logic [7:0] ad;
    } esperado_t;

    logic       clk = 1'b0;
    logic       reset, iniciar, a_zero, instr_pronta;
    logic [7:0] ler_endereco, instrucao_in, pc;
    logic       instr_valida, ocupado, erro;
    logic [3:0] opcode, operando;

    logic       reset2, iniciar2, a_zero2, instr_pronta2;
    logic [7:0] ler_endereco2, instrucao_in2, pc2;
    logic       instr_valida2, ocupado2, erro2;
    logic [3:0] opcode2, operando2;

    int n_cmp = 0;
    int n_err = 0;
    esperado_t fila[$];
    logic valida_ant = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [7:0] ad);
        case (ad)
            8'h00: return 8'h61;
            8'h01: return 8'h69;
            8'h02: return 8'h46;
            8'h03: return 8'h05;
            8'h04: return 8'h37;
            8'h05: return 8'h14;
            8'h06: return 8'h26;
            8'h07: return 8'h57;
            8'h08: return 8'h75;
            8'h09: return 8'h85;
            8'hFF: return 8'h61;
            default: return 8'h00;
        endcase
    endfunction

    assign instrucao_in  = rom(ler_endereco);
    assign instrucao_in2 = rom(ler_endereco2);

    busca_instrucao #(.PC_INICIAL(8'h00)) u_dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .ler_endereco(ler_endereco),
        .instrucao_in(instrucao_in), .a_zero(a_zero), .instr_valida(instr_valida),
        .instr_pronta(instr_pronta), .opcode(opcode), .operando(operando),
        .pc(pc), .ocupado(ocupado), .erro(erro)
    );

    busca_instrucao #(.PC_INICIAL(8'hFF)) u_dut_ff (
        .clk(clk), .reset(reset2), .iniciar(iniciar2), .ler_endereco(ler_endereco2),
        .instrucao_in(instrucao_in2), .a_zero(a_zero2), .instr_valida(instr_valida2),
        .instr_pronta(instr_pronta2), .opcode(opcode2), .operando(operando2),
        .pc(pc2), .ocupado(ocupado2), .erro(erro2)
    );

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_cmp++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input logic [7:0] ad);
        int k;
        for (k = 0; k < 200; k++) begin
            if (instr_valida && ler_endereco == ad) break;
            step();
        end
        check($sformatf("wait_emite_%0h", ad), {31'd0, k < 200}, 32'd1);
    endtask

    task automatic empurra(input logic [7:0] ad);
        esperado_t e;
        logic [7:0] w;
        w = rom(ad);
        e.op = w[7:4];
        e.opnd = w[3:0];
        e.ad = ad;
        fila.push_back(e);
    endtask

    // Monitor: each new instruction presented is compared against the scoreboard.
    always @(negedge clk) begin
        if (!reset && instr_valida && !valida_ant) begin
            if (fila.size() == 0) begin
                check("sb_unexpected_instr", {24'd0, ler_endereco}, 32'hFFFF);
            end else begin
                esperado_t e;
                e = fila.pop_front();
                check("sb_opcode",   {28'd0, opcode},   {28'd0, e.op});
                check("sb_operando", {28'd0, operando}, {28'd0, e.opnd});
                check("sb_endereco", {24'd0, ler_endereco}, {24'd0, e.ad});
            end
        end
        valida_ant = reset ? 1'b0 : instr_valida;
    end

    initial begin
        reset = 1'b1; iniciar = 1'b0; a_zero = 1'b0; instr_pronta = 1'b1;
        reset2 = 1'b1; iniciar2 = 1'b0; a_zero2 = 1'b0; instr_pronta2 = 1'b0;
        step();
        step();
        reset = 1'b0;
        reset2 = 1'b0;

        check("rst_pc",       {24'd0, pc}, 32'h00);
        check("rst_endereco", {24'd0, ler_endereco}, 32'h00);
        check("rst_opcode",   {28'd0, opcode}, 32'h0);
        check("rst_operando", {28'd0, operando}, 32'h0);
        check("rst_valida",   {31'd0, instr_valida}, 32'd0);
        check("rst_ocupado",  {31'd0, ocupado}, 32'd0);
        check("rst_erro",     {31'd0, erro}, 32'd0);
        step();
        check("idle_no_start", {31'd0, ocupado}, 32'd0);

        for (int i = 0; i <= 8; i++) empurra(i[7:0]);
        for (int i = 5; i <= 8; i++) empurra(i[7:0]);

        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        check("start_busca_ocupado", {31'd0, ocupado}, 32'd1);
        check("start_busca_valida",  {31'd0, instr_valida}, 32'd0);
        step();
        check("start_valida_e2", {31'd0, instr_valida}, 32'd1);
        step();
        check("step_pc_01", {24'd0, ler_endereco}, 32'h01);

        wait_for(8'h03);
        instr_pronta = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valida",   {31'd0, instr_valida}, 32'd1);
            check("bp_opcode",   {28'd0, opcode}, 32'h0);
            check("bp_operando", {28'd0, operando}, 32'h5);
            check("bp_pc",       {24'd0, pc}, 32'h03);
        end
        instr_pronta = 1'b1;
        step();
        check("bp_release_pc", {24'd0, pc}, 32'h04);

        wait_for(8'h08);
        a_zero = 1'b1;
        step();
        a_zero = 1'b0;
        check("jmp_taken_pc", {24'd0, ler_endereco}, 32'h05);
        step();
        check("jmp_taken_word", {24'd0, opcode, operando}, 32'h14);

        wait_for(8'h08);
        a_zero = 1'b0;
        step();
        check("jmp_not_taken_pc", {24'd0, pc}, 32'h09);
        step();
        check("trap_erro",   {31'd0, erro}, 32'd1);
        check("trap_valida", {31'd0, instr_valida}, 32'd0);
        check("trap_word",   {24'd0, opcode, operando}, 32'h85);
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step();
        step();
        check("trap_sticky",  {31'd0, erro}, 32'd1);
        check("trap_pc",      {24'd0, pc}, 32'h09);
        check("trap_ocupado", {31'd0, ocupado}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("trap_clear_erro", {31'd0, erro}, 32'd0);
        check("trap_clear_pc",   {24'd0, pc}, 32'h00);

        check("rst2_pc", {24'd0, pc2}, 32'hFF);
        iniciar2 = 1'b1;
        step();
        iniciar2 = 1'b0;
        step();
        check("wrap_word", {24'd0, opcode2, operando2}, 32'h61);
        instr_pronta2 = 1'b1;
        step();
        check("wrap_pc", {24'd0, pc2}, 32'h00);
        step();
        check("wrap_emite_again", {31'd0, instr_valida2}, 32'd1);
        reset2 = 1'b1;
        step();
        reset2 = 1'b0;
        check("midrst_pc",      {24'd0, pc2}, 32'hFF);
        check("midrst_valida",  {31'd0, instr_valida2}, 32'd0);
        check("midrst_ocupado", {31'd0, ocupado2}, 32'd0);

        check("sb_drained", fila.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction fetch/decode unit for the 8-bit accumulator CPU: the reader side of the program ROM. It drives the 8-bit ROM read address, captures the returned instruction into an instruction register, and splits it into 4-bit opcode and 4-bit operand. It hands each instruction to the execute stage over a valid/ready handshake, then advances the program counter, taking `JMP` when the execute stage reports A==0.

## Interface
Parameters:
- `PC_INICIAL`, 8'h00, program counter value after reset.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `iniciar`  in  1  start request; sampled only in `OCIOSO`.
- `ler_endereco`  out  8  ROM read address; always equals the PC register.
- `instrucao_in`  in  8  ROM data; combinational function of `ler_endereco`.
- `a_zero`  in  1  execute-stage flag, A==0.
- `instr_valida`  out  1  opcode/operand valid to execute stage.
- `instr_pronta`  in  1  execute stage accepts the current instruction.
- `opcode`  out  4  IR[7:4].
- `operando`  out  4  IR[3:0].
- `pc`  out  8  current PC, for debug.
- `ocupado`  out  1  high in `BUSCA` and `EMITE`.
- `erro`  out  1  illegal opcode trapped; sticky until reset.

## Operation
- Opcodes: ADD 0000, SUB 0001, LDA 0010, STA 0011, LDB 0100, STB 0101, LDC 0110, JMP 0111. Any opcode with IR[7]=1 is illegal.
- States:
  - `OCIOSO`: idle.
  - `BUSCA`: drive PC and capture the ROM word.
  - `EMITE`: present the instruction and wait for the handshake.
  - `ERRO`: trapped.
- Transitions:
  - `OCIOSO` goes to `BUSCA` when `iniciar`=1; otherwise it stays.
  - `BUSCA` always lasts 1 cycle. At its closing edge, IR <= `instrucao_in`. The next state is `ERRO` if `instrucao_in[7]`=1, else `EMITE`.
  - `EMITE` holds while `instr_pronta`=0. The IR, `opcode` and `operando` stay stable.
  - Transfer occurs on an edge where `instr_valida`=1 and `instr_pronta`=1. The next state is `BUSCA` and the PC updates:
    - If opcode is JMP and `a_zero`=1 at that edge: PC <= {4'h0, operando}.
    - Otherwise: PC <= PC+1, modulo 256, so 8'hFF wraps to 8'h00.
  - `ERRO` is left only by `reset`. While in `ERRO`: `erro`=1, `instr_valida`=0, and the PC is frozen at the address of the illegal word.
- `instr_valida` is 1 exactly in `EMITE`. `opcode` and `operando` are driven from the IR in every state.
- `iniciar` is ignored outside `OCIOSO`.
- No instruction executes from `OCIOSO`. The block runs continuously after one `iniciar` pulse.

## Timing
- Reset values (the cycle after `reset`=1 is sampled):
  - State `OCIOSO`; PC = `PC_INICIAL`, so `ler_endereco` = `pc` = `PC_INICIAL`.
  - IR = 8'h00, so `opcode` = 0 and `operando` = 0.
  - `instr_valida`=0, `ocupado`=0, `erro`=0.
- `reset` overrides every other input in the same cycle. Reset mid-handshake drops the pending instruction and does not update the PC from it.
- Start latency: `iniciar` sampled at edge E puts the block in `BUSCA` during cycle E+1. `instr_valida`=1 from edge E+2.
- Throughput: at most one instruction per 2 cycles, with `instr_pronta` held at 1.
- `ler_endereco` changes only on the PC-update edge. The ROM has a full cycle, the `BUSCA` cycle, to settle.
- `a_zero` is sampled only on the transfer edge of a JMP. The execute stage must present the flag produced by the previous instruction.
- JMP with `a_zero`=0 behaves exactly like a non-jump instruction.

## Structure
- Shared package `pacote_cpu`:
  - opcode localparams: `OP_ADD` … `OP_JMP`.
  - instruction field widths: 4/4.
  - state encoding: `OCIOSO`, `BUSCA`, `EMITE`, `ERRO`.
  - The execute stage uses the same package.
- One sub-module, `contador_programa`:
  - 8-bit register with synchronous reset to `PC_INICIAL`, `carregar` (with 8-bit value) and `incrementar` inputs.
  - Load has priority over increment.
  - Wraps modulo 256.
- The FSM and IR live in `busca_instrucao`.

## Test plan
The bench uses a combinational ROM model loaded with: 0x61, 0x69, 0x46, 0x05, 0x37, 0x14, 0x26, 0x57, 0x75, 0x85.
- **Reset and start.** Hold `reset` 2 cycles, pulse `iniciar`, keep `instr_pronta`=1.
  - `ler_endereco` steps 00 → 01 → 02 …, every 2 cycles.
  - `opcode`/`operando` show 6/1, then 6/9, then 4/6.
  - `instr_valida` first rises 2 cycles after `iniciar`.
- **Backpressure.** At address 03, hold `instr_pronta`=0 for 5 cycles.
  - `instr_valida` stays 1; `opcode`=0 and `operando`=5 stay stable; PC stays 03.
  - On release, PC becomes 04.
- **Jump taken.** Word 0x75 at address 08, with `a_zero`=1 at the transfer edge → next `ler_endereco`=05 and the fetched word is 0x14.
- **Jump not taken.** Same as above with `a_zero`=0 → PC=09 and the fetched word is 0x85.
- **Illegal opcode.** Fetch of 0x85 at address 09:
  - `erro`=1 and `instr_valida`=0 from the next cycle; PC stays 09.
  - `iniciar` pulses are ignored; only `reset` clears `erro`.
- **Wrap-around and mid-operation reset.**
  - With `PC_INICIAL`=8'hFF and word 0x61 at FF: after transfer, PC = 00.
  - Assert `reset` while in `EMITE` → next cycle PC=FF, `instr_valida`=0, `ocupado`=0.
